// File: rtl/bsg_print_stat_snoop_multi.sv
// bsg_print_stat_snoop_multi
// Snoops several manycore request links for stores to the print-stat EPA.
// Each hit is captured with a timestamp into a per-link FIFO.
// The captured events are drained through one round-robin valid/yumi port.
module bsg_print_stat_snoop_multi #(
   parameter int unsigned               num_links_p      = 2,
   parameter int unsigned               addr_width_p     = 28,
   parameter int unsigned               data_width_p     = 32,
   parameter logic [addr_width_p-1:0]   print_stat_epa_p = 'h0D0,
   parameter int unsigned               fifo_els_p       = 4,
   parameter int unsigned               ts_width_p       = 64,
   parameter int unsigned               drop_width_p     = 16,
   localparam int unsigned              lg_links_lp      = (num_links_p > 1) ? $clog2(num_links_p) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_i,
   input  logic                                 en_i,
   input  logic [num_links_p-1:0]               pkt_fire_i,
   input  logic [num_links_p-1:0]               pkt_store_i,
   input  logic [num_links_p*addr_width_p-1:0]  pkt_addr_i,
   input  logic [num_links_p*data_width_p-1:0]  pkt_data_i,
   output logic                                 v_o,
   output logic [data_width_p-1:0]              tag_o,
   output logic [lg_links_lp-1:0]               link_o,
   output logic [ts_width_p-1:0]                ts_o,
   input  logic                                 yumi_i,
   output logic [drop_width_p-1:0]              drop_cnt_o
);

   localparam int unsigned lg_els_lp = $clog2(fifo_els_p);
   localparam int unsigned cnt_w_lp  = drop_width_p + 5;

   logic [ts_width_p-1:0]    r_ts;
   logic [data_width_p-1:0]  r_tag_mem [num_links_p][fifo_els_p];
   logic [ts_width_p-1:0]    r_ts_mem  [num_links_p][fifo_els_p];
   logic [lg_els_lp-1:0]     r_rd_ptr  [num_links_p];
   logic [lg_els_lp-1:0]     r_wr_ptr  [num_links_p];
   logic [num_links_p-1:0]   r_full;
   logic [lg_links_lp-1:0]   r_rr;
   logic [drop_width_p-1:0]  r_drop;

   logic [num_links_p-1:0]   w_hit;
   logic [num_links_p-1:0]   w_enq;
   logic [num_links_p-1:0]   w_deq;
   logic [num_links_p-1:0]   w_nonempty;
   logic [cnt_w_lp-1:0]      w_drop_num;
   logic [cnt_w_lp-1:0]      w_drop_sum;
   logic [drop_width_p-1:0]  w_drop_next;
   logic                     w_v;
   logic [lg_links_lp-1:0]   w_sel;
   logic [lg_links_lp-1:0]   w_lo;
   logic [lg_links_lp-1:0]   w_hi;
   logic                     w_hi_v;

   // Hit detection, enqueue/drop decisions and saturating drop count update
   always_comb begin
      w_hit      = '0;
      w_enq      = '0;
      w_nonempty = '0;
      w_drop_num = '0;
      for (int unsigned i = 0; i < num_links_p; i++) begin
         w_hit[i] = en_i & pkt_fire_i[i] & pkt_store_i[i]
                  & (pkt_addr_i[i*addr_width_p +: addr_width_p] == print_stat_epa_p);
         w_enq[i] = w_hit[i] & ~r_full[i];
         w_nonempty[i] = r_full[i] | (r_rd_ptr[i] != r_wr_ptr[i]);
         if (w_hit[i] & r_full[i])
            w_drop_num = w_drop_num + cnt_w_lp'(1);
      end
      w_drop_sum = cnt_w_lp'(r_drop) + w_drop_num;
      if (w_drop_sum > cnt_w_lp'({drop_width_p{1'b1}}))
         w_drop_next = '1;
      else
         w_drop_next = w_drop_sum[drop_width_p-1:0];
   end

   // Round-robin pick: the lowest non-empty link at or above r_rr wins,
   // otherwise the lowest non-empty link overall (same as a wrapping scan)
   always_comb begin
      w_lo   = '0;
      w_hi   = '0;
      w_hi_v = 1'b0;
      for (int unsigned j = num_links_p; j > 0; j--) begin
         if (w_nonempty[j-1])
            w_lo = lg_links_lp'(j-1);
         if (w_nonempty[j-1] && (lg_links_lp'(j-1) >= r_rr)) begin
            w_hi   = lg_links_lp'(j-1);
            w_hi_v = 1'b1;
         end
      end
      w_v   = |w_nonempty;
      w_sel = w_hi_v ? w_hi : w_lo;
      w_deq = '0;
      for (int unsigned i = 0; i < num_links_p; i++)
         w_deq[i] = yumi_i & w_v & (w_sel == lg_links_lp'(i));
   end

   // Output head of the selected FIFO, zero when nothing is queued
   always_comb begin
      v_o        = w_v;
      tag_o      = w_v ? r_tag_mem[w_sel][r_rd_ptr[w_sel]] : '0;
      ts_o       = w_v ? r_ts_mem[w_sel][r_rd_ptr[w_sel]]  : '0;
      link_o     = w_v ? w_sel : '0;
      drop_cnt_o = r_drop;
   end

   // Free-running timestamp, independent of the capture enable
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         r_ts <= '0;
      else
         r_ts <= r_ts + ts_width_p'(1);
   end

   // FIFO storage writes; contents are don't-care until the pointers say otherwise
   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < num_links_p; i++) begin
         if (w_enq[i]) begin
            r_tag_mem[i][r_wr_ptr[i]] <= pkt_data_i[i*data_width_p +: data_width_p];
            r_ts_mem[i][r_wr_ptr[i]]  <= r_ts;
         end
      end
   end

   // FIFO pointers, full flags, round-robin pointer and drop counter
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int unsigned i = 0; i < num_links_p; i++) begin
            r_rd_ptr[i] <= '0;
            r_wr_ptr[i] <= '0;
         end
         r_full <= '0;
         r_rr   <= '0;
         r_drop <= '0;
      end else begin
         for (int unsigned i = 0; i < num_links_p; i++) begin
            if (w_enq[i])
               r_wr_ptr[i] <= r_wr_ptr[i] + lg_els_lp'(1);
            if (w_deq[i])
               r_rd_ptr[i] <= r_rd_ptr[i] + lg_els_lp'(1);
            if (w_enq[i] && !w_deq[i])
               r_full[i] <= ((r_wr_ptr[i] + lg_els_lp'(1)) == r_rd_ptr[i]);
            else if (w_deq[i] && !w_enq[i])
               r_full[i] <= 1'b0;
         end
         if (yumi_i && w_v)
            r_rr <= (w_sel == lg_links_lp'(num_links_p - 1)) ? '0 : w_sel + lg_links_lp'(1);
         r_drop <= w_drop_next;
      end
   end

   // Consumer must only take an event that is being offered
   assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> w_v);

endmodule

// File: tb/tb_bsg_print_stat_snoop_multi.sv
// Testbench for bsg_print_stat_snoop_multi: queue-based reference model,
// negedge monitor/scoreboard, directed scenarios plus a randomized phase.
module tb_bsg_print_stat_snoop_multi;

   localparam int NL   = 3;
   localparam int AW   = 28;
   localparam int DW   = 32;
   localparam int FE   = 4;
   localparam int TW   = 64;
   localparam int DRW  = 2;
   localparam int LW   = 2;
   localparam int MAXD = 3;
   localparam logic [AW-1:0] EPA = 28'h00000D0;

   logic              clk_i = 1'b0;
   logic              reset_n_i = 1'b0;
   logic              en_i = 1'b1;
   logic [NL-1:0]     pkt_fire_i = '0;
   logic [NL-1:0]     pkt_store_i = '0;
   logic [NL*AW-1:0]  pkt_addr_i = '0;
   logic [NL*DW-1:0]  pkt_data_i = '0;
   logic              v_o;
   logic [DW-1:0]     tag_o;
   logic [LW-1:0]     link_o;
   logic [TW-1:0]     ts_o;
   logic              yumi_i = 1'b0;
   logic [DRW-1:0]    drop_cnt_o;

   bsg_print_stat_snoop_multi #(
      .num_links_p(NL), .addr_width_p(AW), .data_width_p(DW),
      .print_stat_epa_p(EPA), .fifo_els_p(FE), .ts_width_p(TW),
      .drop_width_p(DRW)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i),
      .pkt_fire_i(pkt_fire_i), .pkt_store_i(pkt_store_i),
      .pkt_addr_i(pkt_addr_i), .pkt_data_i(pkt_data_i),
      .v_o(v_o), .tag_o(tag_o), .link_o(link_o), .ts_o(ts_o),
      .yumi_i(yumi_i), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: per-link event queues, rotating priority, drop tally
   typedef struct { logic [DW-1:0] tag; logic [TW-1:0] ts; } ev_t;
   ev_t          mq [NL][$];
   int           m_rr   = 0;
   int           m_drop = 0;
   logic [TW-1:0] m_ts  = '0;

   function automatic int model_sel();
      for (int k = 0; k < NL; k++) begin
         int j;
         j = (m_rr + k) % NL;
         if (mq[j].size() > 0) return j;
      end
      return -1;
   endfunction

   function automatic bit model_hit(input int i);
      return en_i && pkt_fire_i[i] && pkt_store_i[i] && (pkt_addr_i[i*AW +: AW] == EPA);
   endfunction

   always @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < NL; i++) mq[i].delete();
         m_rr = 0; m_drop = 0; m_ts = '0;
      end else begin
         int s;
         bit was_full [NL];
         s = model_sel();
         for (int i = 0; i < NL; i++) was_full[i] = (mq[i].size() == FE);
         if (yumi_i && s >= 0) begin
            void'(mq[s].pop_front());
            m_rr = (s + 1) % NL;
         end
         for (int i = 0; i < NL; i++) begin
            if (model_hit(i)) begin
               if (was_full[i]) m_drop = (m_drop < MAXD) ? m_drop + 1 : MAXD;
               else begin
                  ev_t e;
                  e.tag = pkt_data_i[i*DW +: DW];
                  e.ts  = m_ts;
                  mq[i].push_back(e);
               end
            end
         end
         m_ts = m_ts + 64'd1;
      end
   end

   // Monitor: compare the offered head against the model every cycle
   always @(negedge clk_i) begin
      int s;
      s = model_sel();
      check("v_o", 64'(v_o), 64'(s >= 0));
      if (s >= 0) begin
         check("tag_o", 64'(tag_o), 64'(mq[s][0].tag));
         check("link_o", 64'(link_o), 64'(s));
         check("ts_o", ts_o, mq[s][0].ts);
      end else begin
         check("tag_o_idle", 64'(tag_o), 64'd0);
         check("link_o_idle", 64'(link_o), 64'd0);
         check("ts_o_idle", ts_o, 64'd0);
      end
      check("drop_cnt_o", 64'(drop_cnt_o), 64'(m_drop));
   end

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic clr();
      en_i = 1'b1; pkt_fire_i = '0; pkt_store_i = '0; pkt_addr_i = '0; pkt_data_i = '0;
   endtask

   task automatic hit(input int i, input logic [DW-1:0] d);
      pkt_fire_i[i] = 1'b1;
      pkt_store_i[i] = 1'b1;
      pkt_addr_i[i*AW +: AW] = EPA;
      pkt_data_i[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      reset_n_i = 1'b0;
      tick();
      reset_n_i = 1'b1;
   endtask

   int order[$];

   task automatic drain(input int max, input bit rec);
      int n = 0;
      while (model_sel() >= 0 && n < max) begin
         yumi_i = 1'b1;
         if (rec) order.push_back(int'(link_o));
         tick();
         n++;
      end
      yumi_i = 1'b0;
      check("drain_within_bound", 64'(model_sel() < 0), 64'd1);
   endtask

   initial begin
      logic [TW-1:0] ts_a;
      int guard;
      clr();
      // reset state
      #2;
      check("rst_v_o", 64'(v_o), 64'd0);
      check("rst_tag_o", 64'(tag_o), 64'd0);
      check("rst_ts_o", ts_o, 64'd0);
      check("rst_link_o", 64'(link_o), 64'd0);
      check("rst_drop", 64'(drop_cnt_o), 64'd0);
      tick();
      reset_n_i = 1'b1;

      // single hit captured at ts 10
      guard = 0;
      while (m_ts != 64'd10 && guard < 50) begin tick(); guard++; end
      check("reach_ts10", m_ts, 64'd10);
      hit(0, 32'hCAFE0001);
      tick();
      clr();
      check("single_v", 64'(v_o), 64'd1);
      check("single_tag", 64'(tag_o), 64'hCAFE0001);
      check("single_link", 64'(link_o), 64'd0);
      check("single_ts", ts_o, 64'd10);
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
      check("single_after_yumi", 64'(v_o), 64'd0);

      // non-hits: disabled, non-store, wrong address
      hit(0, 32'h11111111); en_i = 1'b0; tick(); clr();
      hit(0, 32'h22222222); pkt_store_i[0] = 1'b0; tick(); clr();
      hit(1, 32'h33333333); pkt_addr_i[1*AW +: AW] = EPA + 28'd1; tick(); clr();
      tick();
      check("nonhit_v", 64'(v_o), 64'd0);
      check("nonhit_drop", 64'(drop_cnt_o), 64'd0);

      // round-robin pair with equal timestamps
      do_reset();
      hit(0, 32'hA0); hit(1, 32'hA1); tick(); clr();
      yumi_i = 1'b1;
      check("rr_first_link", 64'(link_o), 64'd0);
      ts_a = ts_o;
      tick();
      check("rr_second_link", 64'(link_o), 64'd1);
      check("rr_equal_ts", ts_o, ts_a);
      tick();
      yumi_i = 1'b0;
      check("rr_pair_empty", 64'(v_o), 64'd0);

      // three hits on links 0 and 1, then continuous drain
      for (int k = 0; k < 3; k++) begin
         hit(0, 32'hB0 + k); hit(1, 32'hC0 + k); tick();
      end
      clr();
      order.delete();
      drain(20, 1'b1);
      check("rr_order_len", 64'(order.size()), 64'd6);
      for (int k = 0; k < 6 && k < order.size(); k++)
         check("rr_order", 64'(order[k]), 64'(k % 2));

      // overflow on link 1, then drop saturation
      for (int k = 0; k < 5; k++) begin hit(1, 32'hD0 + k); tick(); end
      clr();
      check("ovf_drop1", 64'(drop_cnt_o), 64'd1);
      hit(1, 32'hD5); yumi_i = 1'b1; tick(); clr(); yumi_i = 1'b0;
      check("ovf_drop2", 64'(drop_cnt_o), 64'd2);
      for (int k = 0; k < 5; k++) begin hit(1, 32'hE0 + k); tick(); end
      clr();
      check("drop_saturated", 64'(drop_cnt_o), 64'd3);

      // async reset mid-drain with three entries queued
      yumi_i = 1'b1; tick(); yumi_i = 1'b0;
      check("pre_reset_v", 64'(v_o), 64'd1);
      @(posedge clk_i);
      #2 reset_n_i = 1'b0;
      #1;
      check("async_rst_v", 64'(v_o), 64'd0);
      check("async_rst_drop", 64'(drop_cnt_o), 64'd0);
      check("async_rst_tag", 64'(tag_o), 64'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      hit(2, 32'h12345678);
      tick();
      clr();
      check("post_rst_link", 64'(link_o), 64'd2);
      check("post_rst_ts", ts_o, 64'd0);
      check("post_rst_tag", 64'(tag_o), 64'h12345678);
      drain(10, 1'b0);

      // randomized traffic
      do_reset();
      for (int c = 0; c < 400; c++) begin
         en_i = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < NL; i++) begin
            pkt_fire_i[i]  = 1'($urandom_range(0, 1));
            pkt_store_i[i] = ($urandom_range(0, 3) != 0);
            pkt_addr_i[i*AW +: AW] = ($urandom_range(0, 3) != 0) ? EPA : AW'($urandom);
            pkt_data_i[i*DW +: DW] = $urandom;
         end
         yumi_i = (model_sel() >= 0) && ($urandom_range(0, 2) != 0);
         tick();
      end
      clr();
      drain(64, 1'b0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
